// File: rtl/secure_boot_sequencer.sv
// secure_boot_sequencer: drives the crypto accelerator at power-up,
// verifies the firmware HMAC against OTP and gates the CPU reset.
module secure_boot_sequencer #(
  parameter logic [31:0] FW_BASE      = 32'h0000_0000,
  parameter logic [31:0] FW_LEN       = 32'h0000_1000,
  parameter logic [31:0] POLL_TIMEOUT = 32'd1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         otp_valid,
  input  logic [255:0] otp_key,
  input  logic [255:0] otp_mac,
  output logic [7:0]   acc_addr,
  output logic         acc_we,
  output logic [31:0]  acc_wdata,
  input  logic [31:0]  acc_rdata,
  output logic         cpu_rst_n,
  output logic         boot_done,
  output logic         boot_pass,
  output logic         boot_fail,
  output logic [1:0]   fail_code
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WR_KEY = 4'd1;
  localparam logic [3:0] S_WR_MOD = 4'd2;
  localparam logic [3:0] S_WR_ADR = 4'd3;
  localparam logic [3:0] S_WR_LEN = 4'd4;
  localparam logic [3:0] S_WR_GO  = 4'd5;
  localparam logic [3:0] S_POLL   = 4'd6;
  localparam logic [3:0] S_RD     = 4'd7;
  localparam logic [3:0] S_CHECK  = 4'd8;
  localparam logic [3:0] S_PASS   = 4'd9;
  localparam logic [3:0] S_FAIL   = 4'd10;

  localparam logic [1:0] FC_MAC = 2'd1;
  localparam logic [1:0] FC_ERR = 2'd2;
  localparam logic [1:0] FC_TMO = 2'd3;

  logic [3:0]   state;
  logic [2:0]   k;
  logic [255:0] key_q;
  logic [31:0]  poll_cnt;
  logic [31:0]  mism;
  logic [31:0]  mac_word;
  logic         poll_last;

  // Reference MAC word matching the hash word on the bus
  always_comb begin
    mac_word = otp_mac[{~k, 5'b0} +: 32];
  end

  // Poll budget exhausted once this sample is the last allowed one
  always_comb begin
    poll_last = (poll_cnt >= POLL_TIMEOUT - 32'd1);
  end

  // Sequencer: bus outputs are registered for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      key_q     <= '0;
      poll_cnt  <= '0;
      mism      <= '0;
      acc_addr  <= '0;
      acc_we    <= 1'b0;
      acc_wdata <= '0;
      cpu_rst_n <= 1'b0;
      boot_done <= 1'b0;
      boot_pass <= 1'b0;
      boot_fail <= 1'b0;
      fail_code <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          acc_we <= 1'b0;
          if (otp_valid) begin
            state     <= S_WR_KEY;
            k         <= '0;
            key_q     <= otp_key;
            acc_we    <= 1'b1;
            acc_addr  <= 8'h05;
            acc_wdata <= otp_key[255:224];
          end
        end
        S_WR_KEY: begin
          if (k == 3'd7) begin
            state     <= S_WR_MOD;
            key_q     <= '0;
            acc_addr  <= 8'h02;
            acc_wdata <= 32'h1;
          end else begin
            k         <= k + 3'd1;
            key_q     <= {key_q[223:0], 32'h0};
            acc_addr  <= acc_addr + 8'd1;
            acc_wdata <= key_q[223:192];
          end
        end
        S_WR_MOD: begin
          state     <= S_WR_ADR;
          acc_addr  <= 8'h03;
          acc_wdata <= FW_BASE;
        end
        S_WR_ADR: begin
          state     <= S_WR_LEN;
          acc_addr  <= 8'h04;
          acc_wdata <= FW_LEN;
        end
        S_WR_LEN: begin
          state     <= S_WR_GO;
          acc_addr  <= 8'h00;
          acc_wdata <= 32'h1;
        end
        S_WR_GO: begin
          state     <= S_POLL;
          poll_cnt  <= '0;
          acc_we    <= 1'b0;
          acc_addr  <= 8'h01;
          acc_wdata <= '0;
        end
        S_POLL: begin
          if (acc_rdata[2]) begin
            state     <= S_FAIL;
            acc_addr  <= '0;
            boot_done <= 1'b1;
            boot_fail <= 1'b1;
            fail_code <= FC_ERR;
          end else if (acc_rdata[1]) begin
            state    <= S_RD;
            k        <= '0;
            mism     <= '0;
            acc_addr <= 8'h10;
          end else if (poll_last) begin
            state     <= S_FAIL;
            acc_addr  <= '0;
            boot_done <= 1'b1;
            boot_fail <= 1'b1;
            fail_code <= FC_TMO;
          end else if (poll_cnt != '1) begin
            poll_cnt <= poll_cnt + 32'd1;
          end
        end
        S_RD: begin
          mism <= mism | (acc_rdata ^ mac_word);
          if (k == 3'd7) begin
            state    <= S_CHECK;
            acc_addr <= '0;
          end else begin
            k        <= k + 3'd1;
            acc_addr <= acc_addr + 8'd1;
          end
        end
        S_CHECK: begin
          boot_done <= 1'b1;
          if (mism == '0) begin
            state     <= S_PASS;
            boot_pass <= 1'b1;
            cpu_rst_n <= 1'b1;
          end else begin
            state     <= S_FAIL;
            boot_fail <= 1'b1;
            fail_code <= FC_MAC;
          end
        end
        S_PASS: begin
          acc_we <= 1'b0;
        end
        S_FAIL: begin
          acc_we <= 1'b0;
        end
        default: begin
          state     <= S_FAIL;
          acc_we    <= 1'b0;
          boot_done <= 1'b1;
          boot_fail <= 1'b1;
          fail_code <= FC_ERR;
        end
      endcase
    end
  end

endmodule

// File: doc/secure_boot_sequencer.md
# secure_boot_sequencer

Hardware root-of-trust sequencer that sits directly upstream of the crypto accelerator and drives its register port in place of the CPU at power-up. After reset it loads the OTP key and firmware region into the accelerator and runs HMAC-SHA256. It reads back the 256-bit MAC, compares it against the OTP reference MAC, and releases the CPU reset only on a full match. The result is exported as sticky status for the SoC.

## Interface
Parameters:
- FW_BASE, 32'h0000_0000, byte address of the firmware image; written to MSG_ADDR.
- FW_LEN, 32'h0000_1000, firmware length in bytes; written to MSG_LEN. Nonzero multiple of 4.
- POLL_TIMEOUT, 32'd1_000_000, maximum number of STATUS poll cycles before declaring a timeout.

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- otp_valid  in  1  OTP key and MAC are stable; sampled only in IDLE.
- otp_key  in  256  HMAC key; [255:224] is key word 0.
- otp_mac  in  256  expected MAC; [255:224] is hash word 0.
- acc_addr  out  8  accelerator word address (byte offset / 4).
- acc_we  out  1  accelerator write enable.
- acc_wdata  out  32  accelerator write data.
- acc_rdata  in  32  accelerator read data; combinational from the accelerator for the current acc_addr.
- cpu_rst_n  out  1  CPU reset, active-low; released only on pass.
- boot_done  out  1  sequence finished, either pass or fail.
- boot_pass  out  1  MAC matched.
- boot_fail  out  1  verification failed.
- fail_code  out  2  failure cause: 0 none, 1 MAC mismatch, 2 accelerator error, 3 timeout.

## Operation
- All outputs are registered. Reset values:
  - acc_addr = 0, acc_we = 0, acc_wdata = 0.
  - cpu_rst_n = 0, boot_done = 0, boot_pass = 0, boot_fail = 0, fail_code = 0.
- States and transitions:
  - IDLE: acc_we = 0. Advance to WR_KEY when otp_valid = 1.
  - WR_KEY: 8 consecutive writes of key word k to address 0x05+k, k = 0..7.
  - WR_MODE: write 0x1 (HMAC) to 0x02.
  - WR_ADDR: write FW_BASE to 0x03.
  - WR_LEN: write FW_LEN to 0x04.
  - WR_START: write 0x1 to 0x00.
  - POLL: acc_we = 0, acc_addr = 0x01. Sample STATUS every cycle and check in this priority order:
    - bit2 (ERROR) = 1: FAIL, code 2.
    - bit1 (DONE) = 1: go to RD_HASH.
    - poll counter reaches POLL_TIMEOUT: FAIL, code 3.
  - RD_HASH: 8 cycles, acc_addr = 0x10+k. XOR each sampled word with otp_mac word k and OR the result into a mismatch accumulator.
  - CHECK: accumulator = 0: PASS; otherwise FAIL, code 1.
  - PASS: boot_done = 1, boot_pass = 1, cpu_rst_n = 1.
  - FAIL: boot_done = 1, boot_fail = 1, cpu_rst_n stays 0.
  - PASS and FAIL are terminal and sticky until rst_n.
- The compare is constant-time: all 8 hash words are always read, with no early exit on the first mismatch.
- otp_valid and otp_key are not re-sampled after IDLE. otp_mac is read only during RD_HASH and must stay stable through it.
- The poll counter is 32 bits, cleared on entry to POLL, and does not wrap.
- The mismatch accumulator is cleared on entry to RD_HASH.
- After WR_START the block never writes CTRL again; there is no retry.

## Timing
- One accelerator write per cycle. acc_we is high for exactly 12 consecutive cycles, beginning the cycle after otp_valid is first sampled high in IDLE.
- Every read samples acc_rdata on the same rising edge that holds the matching acc_addr.
- Minimum latency from otp_valid to the result: 12 write cycles + ≥1 poll cycle + 8 read cycles + 1 check cycle.
- The result outputs update together on the edge that enters PASS or FAIL.
- DONE seen on the same cycle the timeout count is reached: DONE wins.
- ERROR and DONE both set on the same cycle: ERROR wins, code 2.
- Reset mid-operation: all outputs return to reset values asynchronously and cpu_rst_n drops immediately. A new sequence starts from IDLE.

## Test plan
- Pass: key = 256'h00..01, model returns DONE after 50 polls with hash words equal to otp_mac -> the 12 writes are observed in order (0x05..0x0C, 0x02=1, 0x03=FW_BASE, 0x04=0x1000, 0x00=1); boot_pass = 1, cpu_rst_n = 1, fail_code = 0.
- Mismatch: hash word 7 returned as otp_mac[31:0]^1 -> all 8 hash addresses 0x10..0x17 are read; boot_fail = 1, fail_code = 1, cpu_rst_n = 0.
- Error: STATUS = 0x4 on poll 3 -> FAIL with fail_code = 2, no reads of 0x10..0x17.
- Timeout: POLL_TIMEOUT = 20, DONE never set -> exactly 20 poll cycles, then fail_code = 3.
- Late otp_valid plus reset: otp_valid held low for 100 cycles -> no writes occur. Then assert it, and assert rst_n low during POLL -> all outputs return to reset values; after reset release the full 12-write sequence repeats.
- Simultaneity: STATUS = 0x6 on the first poll -> fail_code = 2; separately, DONE on the final timeout cycle -> enters RD_HASH.
